alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Controller that sequences the shared 12-bit ALU datapath feeding the 4-digit seven-segment display. It latches an operand pair on a start request, then drives the ALU through either one opcode or a full sweep of all 8 opcodes. After each opcode it captures the ALU result and holds it for a programmable dwell period so the display stage can show it. It sits between the switch/input logic and the combinational ALU; the display driver consumes `res`/`res_op`.

## Interface
Parameters:
- `W`, 12, operand width
- `RW`, 24, ALU result width (full-width product)
- `DWELL`, 3, hold cycles per result; legal range 1..255

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted)
- `start`  in  1  run request; sampled only in IDLE
- `sweep`  in  1  1 = run opcodes 0..7; 0 = run `op_in` only; sampled with `start`
- `x_in`, `y_in`  in  W  operands; sampled with `start`
- `op_in`  in  3  opcode for single mode; sampled with `start`
- `alu_x`, `alu_y`  out  W  operands to ALU
- `alu_op`  out  3  opcode to ALU
- `alu_res`  in  RW  combinational ALU result
- `res`  out  RW  captured result
- `res_op`  out  3  opcode that produced `res`
- `res_valid`  out  1  one-cycle pulse on each new capture
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at end of run

## Operation
- States: IDLE, EXEC, DWELL, DONE.
- IDLE: `start`=1 at an edge latches `x_in`, `y_in` into `alu_x`, `alu_y`. `alu_op` is loaded with 0 if `sweep`=1, else `op_in`. The sweep flag is latched. Next state is EXEC.
- EXEC (1 cycle): the ALU settles on the registered inputs. At the closing edge, `res`<=`alu_res` and `res_op`<=`alu_op`. The dwell counter is loaded with DWELL-1. Next state is DWELL.
- DWELL: `res_valid`=1 in the first DWELL cycle only. The counter decrements each cycle. When the counter is 0:
  - if sweep is latched and `alu_op`!=7: `alu_op`++, go to EXEC;
  - otherwise go to DONE.
- DONE (1 cycle): `done`=1. Next state is IDLE.
- `start` is ignored while `busy`=1. There is no queueing.
- Opcode counter does not wrap: 7 is terminal in sweep mode.
- `res`/`res_op` hold their last value in IDLE until the next capture.
- Input changes on `x_in`/`y_in`/`op_in`/`sweep` mid-run have no effect.
- `reset` asserted at any time, including mid-run: immediate return to IDLE with all outputs cleared. A partially completed sweep is discarded.

## Timing
- Reset value of every output is 0: `alu_x`, `alu_y`, `alu_op`, `res`, `res_op`, `res_valid`, `busy`, `done`.
- All outputs are registered. `alu_res` is the only combinational input path, captured at the end of EXEC.
- Numbering: `start` is sampled at edge k; cycle k+1 is the cycle following that edge.
- `start` sampled at edge k leads to:
  - EXEC in cycle k+1 (`busy`=1);
  - first `res_valid` in cycle k+2;
  - next opcode's EXEC in cycle k+2+DWELL.
- Per-opcode period is 1+DWELL cycles. With DWELL=3 the period is 4 cycles.
- Single run: `done` in cycle k+2+DWELL, IDLE again in k+3+DWELL.
- Sweep run: `done` in cycle k+1+8·(1+DWELL), i.e. 8·(1+DWELL)+1 busy cycles in total.
- A back-to-back `start` is accepted at the edge closing the first IDLE cycle after DONE.

## Configuration
- `ALU_SEQ_ABORT_EN` defined:
  - adds input `abort` (1 bit);
  - `abort`=1 at an edge in EXEC or DWELL moves to DONE next cycle, so `done` pulses and no further `res_valid` is issued;
  - `abort` in IDLE or DONE is ignored.
- Not defined: no `abort` port; runs always complete.

## Structure
- Package `alu_seq_pkg`:
  - state enum (IDLE, EXEC, DWELL, DONE);
  - `OP_W`=3, `NUM_OPS`=8, `LAST_OP`=3'd7.
- Sub-module `seq_dwell_timer`:
  - loadable down-counter of width $clog2(DWELL+1);
  - inputs: `load`, `en`; output: `zero`;
  - same `clk`/`reset`.

## Test plan
The bench ALU model is `alu_res` = `alu_x`+`alu_y`+`alu_op`. DWELL=3 throughout.
- Reset release, no start -> all outputs 0, `busy`=0 indefinitely.
- `x_in`=4, `y_in`=2, `sweep`=1, `start` pulse -> eight `res_valid` pulses 4 cycles apart with `res`=6,7,...,13 and `res_op`=0..7; `done` in the 33rd cycle after `start`.
- `x_in`=201, `y_in`=200, `sweep`=0, `op_in`=5, `start` -> single `res`=406, `res_op`=5, `res_valid` at k+2, `done` at k+5.
- `start` re-pulsed while `busy` and operands changed mid-sweep -> ignored; results unchanged from the original run.
- `reset` asserted during the sweep at `alu_op`=3 -> all outputs 0 immediately; a subsequent `start` runs a clean sweep from opcode 0.
- With `ALU_SEQ_ABORT_EN`: `abort` during the DWELL of opcode 2 -> `done` next cycle, no `res_valid` for opcodes 3..7.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared state encoding and opcode constants for the ALU operation sequencer.
package alu_seq_pkg;

  localparam int OP_W = 3;
  localparam int NUM_OPS = 8;
  localparam logic [OP_W-1:0] LAST_OP = OP_W'(NUM_OPS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DWELL,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/seq_dwell_timer.sv
// Loadable down-counter that measures how long each captured ALU result is held.
module seq_dwell_timer
  import alu_seq_pkg::*;
#(
  parameter int DWELL = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic zero
);

  localparam int CW = $clog2(DWELL + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(DWELL - 1);

  logic [CW-1:0] count;

  // Loading DWELL-1 gives exactly DWELL cycles before zero is seen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (en && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences the shared ALU through one opcode or a full 0..7 sweep, holding each result.
// Optional abort input enabled by defining ALU_SEQ_ABORT_EN.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int W     = 12,
  parameter int RW    = 24,
  parameter int DWELL = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            sweep,
  input  logic [W-1:0]    x_in,
  input  logic [W-1:0]    y_in,
  input  logic [OP_W-1:0] op_in,
`ifdef ALU_SEQ_ABORT_EN
  input  logic            abort,
`endif
  output logic [W-1:0]    alu_x,
  output logic [W-1:0]    alu_y,
  output logic [OP_W-1:0] alu_op,
  input  logic [RW-1:0]   alu_res,
  output logic [RW-1:0]   res,
  output logic [OP_W-1:0] res_op,
  output logic            res_valid,
  output logic            busy,
  output logic            done
);

  seq_state_t state;
  seq_state_t state_next;
  logic       sweep_q;
  logic       abort_req;
  logic       dwell_load;
  logic       dwell_en;
  logic       dwell_zero;

`ifdef ALU_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  seq_dwell_timer #(
    .DWELL(DWELL)
  ) u_dwell_timer (
    .clk  (clk),
    .reset(reset),
    .load (dwell_load),
    .en   (dwell_en),
    .zero (dwell_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    dwell_load = 1'b0;
    dwell_en   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_EXEC;
      end
      S_EXEC: begin
        dwell_load = 1'b1;
        state_next = abort_req ? S_DONE : S_DWELL;
      end
      S_DWELL: begin
        dwell_en = 1'b1;
        if (abort_req) begin
          state_next = S_DONE;
        end else if (dwell_zero) begin
          // Opcode 7 is terminal; the sweep never wraps back to 0.
          state_next = (sweep_q && (alu_op != LAST_OP)) ? S_EXEC : S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Status pulses are decoded from the next state so every output leaves a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_x     <= '0;
      alu_y     <= '0;
      alu_op    <= '0;
      sweep_q   <= 1'b0;
      res       <= '0;
      res_op    <= '0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      busy      <= (state_next != S_IDLE);
      done      <= (state_next == S_DONE);
      res_valid <= (state == S_EXEC) && (state_next == S_DWELL);
      if ((state == S_IDLE) && start) begin
        alu_x   <= x_in;
        alu_y   <= y_in;
        alu_op  <= sweep ? '0 : op_in;
        sweep_q <= sweep;
      end
      if ((state == S_EXEC) && (state_next == S_DWELL)) begin
        res    <= alu_res;
        res_op <= alu_op;
      end
      if ((state == S_DWELL) && (state_next == S_EXEC)) begin
        alu_op <= alu_op + OP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with an adder-style ALU model (x + y + op), DWELL = 3.
module tb_alu_op_sequencer;

  localparam int W  = 12;
  localparam int RW = 24;

  logic          clk = 1'b0;
  logic          resetN;
  logic          startIn;
  logic          sweepIn;
  logic [W-1:0]  xIn;
  logic [W-1:0]  yIn;
  logic [2:0]    opIn;
  logic [W-1:0]  aluX;
  logic [W-1:0]  aluY;
  logic [2:0]    aluOp;
  logic [RW-1:0] aluRes;
  logic [RW-1:0] res;
  logic [2:0]    resOp;
  logic          resValid;
  logic          busy;
  logic          done;
`ifdef ALU_SEQ_ABORT_EN
  logic          abortIn;
`endif

  int compareCount  = 0;
  int mismatchCount = 0;

  always #5 clk = ~clk;

  assign aluRes = RW'(aluX) + RW'(aluY) + RW'(aluOp);

  alu_op_sequencer #(
    .W    (W),
    .RW   (RW),
    .DWELL(3)
  ) dut (
    .clk      (clk),
    .reset    (resetN),
    .start    (startIn),
    .sweep    (sweepIn),
    .x_in     (xIn),
    .y_in     (yIn),
    .op_in    (opIn),
`ifdef ALU_SEQ_ABORT_EN
    .abort    (abortIn),
`endif
    .alu_x    (aluX),
    .alu_y    (aluY),
    .alu_op   (aluOp),
    .alu_res  (aluRes),
    .res      (res),
    .res_op   (resOp),
    .res_valid(resValid),
    .busy     (busy),
    .done     (done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Drives one start request; returns one step after the sampling edge (cycle k+1).
  task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic [2:0] op, input logic sw);
    xIn     = x;
    yIn     = y;
    opIn    = op;
    sweepIn = sw;
    startIn = 1'b1;
    stepCycle();
    startIn = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " alu_x"}, 32'(aluX), 32'd0);
    checkOutput({tag, " alu_y"}, 32'(aluY), 32'd0);
    checkOutput({tag, " alu_op"}, 32'(aluOp), 32'd0);
    checkOutput({tag, " res"}, 32'(res), 32'd0);
    checkOutput({tag, " res_op"}, 32'(resOp), 32'd0);
    checkOutput({tag, " res_valid"}, 32'(resValid), 32'd0);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " done"}, 32'(done), 32'd0);
  endtask

  // Cycles k+1..k+5 of a single-opcode run; ends in the DONE cycle.
  task automatic checkSingle(input int expRes, input int expOp);
    for (int i = 1; i <= 5; i++) begin
      checkOutput("single busy", 32'(busy), 32'd1);
      checkOutput("single res_valid", 32'(resValid), (i == 2) ? 32'd1 : 32'd0);
      checkOutput("single done", 32'(done), (i == 5) ? 32'd1 : 32'd0);
      if (i == 2) begin
        checkOutput("single res", 32'(res), 32'(expRes));
        checkOutput("single res_op", 32'(resOp), 32'(expOp));
      end
      if (i < 5) stepCycle();
    end
  endtask

  // Cycles k+1..k+33 of a sweep; results expected at k+2, k+6, ... k+30.
  task automatic checkSweep(input int expBase, input bit meddle);
    int n;
    for (int i = 1; i <= 33; i++) begin
      checkOutput("sweep busy", 32'(busy), 32'd1);
      checkOutput("sweep done", 32'(done), (i == 33) ? 32'd1 : 32'd0);
      if ((i >= 2) && (((i - 2) % 4) == 0)) begin
        n = (i - 2) / 4;
        checkOutput("sweep res_valid", 32'(resValid), 32'd1);
        checkOutput("sweep res", 32'(res), 32'(expBase + n));
        checkOutput("sweep res_op", 32'(resOp), 32'(n));
      end else begin
        checkOutput("sweep res_valid idle", 32'(resValid), 32'd0);
      end
      if (meddle && (i == 9)) begin
        startIn = 1'b1;
        xIn     = 12'd100;
        yIn     = 12'd300;
        opIn    = 3'd1;
        sweepIn = 1'b0;
      end
      if (meddle && (i == 11)) startIn = 1'b0;
      if (i < 33) stepCycle();
    end
  endtask

  initial begin
    resetN  = 1'b0;
    startIn = 1'b0;
    sweepIn = 1'b0;
    xIn     = '0;
    yIn     = '0;
    opIn    = '0;
`ifdef ALU_SEQ_ABORT_EN
    abortIn = 1'b0;
`endif
    #12;
    checkAllZero("reset");
    resetN = 1'b1;

    for (int i = 0; i < 10; i++) begin
      stepCycle();
      checkOutput("idle busy", 32'(busy), 32'd0);
      checkOutput("idle res_valid", 32'(resValid), 32'd0);
    end

    applyStimulus(12'd4, 12'd2, 3'd0, 1'b1);
    checkSweep(6, 1'b0);
    stepCycle();
    checkOutput("sweep end busy", 32'(busy), 32'd0);
    checkOutput("sweep hold res", 32'(res), 32'd13);
    checkOutput("sweep hold res_op", 32'(resOp), 32'd7);

    applyStimulus(12'd201, 12'd200, 3'd5, 1'b0);
    checkSingle(406, 5);
    xIn     = 12'd1;
    yIn     = 12'd1;
    opIn    = 3'd2;
    startIn = 1'b1;
    stepCycle();
    checkOutput("b2b idle busy", 32'(busy), 32'd0);
    checkOutput("b2b idle res hold", 32'(res), 32'd406);
    stepCycle();
    startIn = 1'b0;
    checkSingle(4, 2);
    stepCycle();
    checkOutput("single end busy", 32'(busy), 32'd0);
    checkOutput("single hold res", 32'(res), 32'd4);

    applyStimulus(12'd4, 12'd2, 3'd0, 1'b1);
    checkSweep(6, 1'b1);
    stepCycle();
    checkOutput("meddle end busy", 32'(busy), 32'd0);

    applyStimulus(12'd4, 12'd2, 3'd0, 1'b1);
    for (int i = 0; i < 13; i++) stepCycle();
    checkOutput("pre-reset alu_op", 32'(aluOp), 32'd3);
    checkOutput("pre-reset busy", 32'(busy), 32'd1);
    resetN = 1'b0;
    #1;
    checkAllZero("mid reset");
    #1;
    resetN = 1'b1;
    stepCycle();
    checkOutput("post reset busy", 32'(busy), 32'd0);
    applyStimulus(12'd10, 12'd1, 3'd0, 1'b1);
    checkSweep(11, 1'b0);
    stepCycle();
    checkOutput("resweep end busy", 32'(busy), 32'd0);

`ifdef ALU_SEQ_ABORT_EN
    applyStimulus(12'd4, 12'd2, 3'd0, 1'b1);
    for (int i = 0; i < 10; i++) stepCycle();
    checkOutput("abort res_op", 32'(resOp), 32'd2);
    abortIn = 1'b1;
    stepCycle();
    abortIn = 1'b0;
    checkOutput("abort done", 32'(done), 32'd1);
    checkOutput("abort res_valid", 32'(resValid), 32'd0);
    for (int i = 0; i < 20; i++) begin
      stepCycle();
      checkOutput("post abort busy", 32'(busy), 32'd0);
      checkOutput("post abort res_valid", 32'(resValid), 32'd0);
    end
    checkOutput("post abort res_op", 32'(resOp), 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
